calc1_port_driver: RTL and testbench

Upstream request sequencer for one calc1 port. Accepts a complete operation (command plus two operands) on a valid/ready interface and serializes it onto the calc1 two-cycle request protocol. It then waits for the port's response, with a timeout, and returns the result on a second valid/ready interface. Four instances, one per port, feed the calc1 under test.

---
 rtl/calc1_pkg.sv | 28 ++
 rtl/calc1_resp_timer.sv | 29 ++
 rtl/calc1_port_driver.sv | 148 ++++++++++++++
 tb/tb_calc1_port_driver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command/response codes and the port driver state encoding.
package calc1_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;
  localparam logic [1:0] RESP_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_CMD  = 3'd1,
    ST_SEND_OP2  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_HOLD_RSP  = 3'd4
  } drv_state_e;

  // Commands that the calc1 port actually implements.
  function automatic logic cmd_allowed(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc1_resp_timer.sv
// Response wait counter: terminal count fires on the TIMEOUT_CYCLES-th enabled cycle after clear.
module calc1_resp_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic c_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign tc = enable && (count == LAST);

endmodule

// File: rtl/calc1_port_driver.sv
// Serializes one calc1 operation onto a port, waits (with timeout) and returns the result.
// Build option: define CALC1_DRV_CMD_FILTER_EN to reject commands the port does not implement.
module calc1_port_driver
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic [3:0]  calc_cmd,
  output logic [31:0] calc_data,
  input  logic [1:0]  calc_resp,
  input  logic [31:0] calc_out_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_code,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        err_spurious,
  output logic [2:0]  dbg_state
);

`ifdef CALC1_DRV_CMD_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a held rsp_* payload stays stable until taken.
  drv_state_e  state, state_d;
  logic        req_ready_d, rsp_valid_d, rsp_timeout_d, err_d;
  logic [3:0]  calc_cmd_d;
  logic [31:0] calc_data_d, rsp_data_d, op2_q, op2_d;
  logic [1:0]  rsp_code_d;
  logic        timer_clr, timer_en, timer_tc;

  calc1_resp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .c_clk  (c_clk),
    .reset  (reset),
    .clear  (timer_clr),
    .enable (timer_en),
    .tc     (timer_tc)
  );

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b0;
      calc_cmd     <= '0;
      calc_data    <= '0;
      rsp_valid    <= 1'b0;
      rsp_code     <= '0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      op2_q        <= '0;
    end else begin
      state        <= state_d;
      req_ready    <= req_ready_d;
      calc_cmd     <= calc_cmd_d;
      calc_data    <= calc_data_d;
      rsp_valid    <= rsp_valid_d;
      rsp_code     <= rsp_code_d;
      rsp_data     <= rsp_data_d;
      rsp_timeout  <= rsp_timeout_d;
      err_spurious <= err_d;
      op2_q        <= op2_d;
    end
  end

  always_comb begin
    state_d       = state;
    calc_cmd_d    = '0;
    calc_data_d   = '0;
    rsp_valid_d   = rsp_valid;
    rsp_code_d    = rsp_code;
    rsp_data_d    = rsp_data;
    rsp_timeout_d = rsp_timeout;
    op2_d         = op2_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;
    // A response code outside WAIT_RESP is flagged and otherwise ignored.
    err_d = err_spurious || ((calc_resp != RESP_NONE) && (state != ST_WAIT_RESP));

    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          op2_d = req_op2;
          if (FILTER_EN && !cmd_allowed(req_cmd)) begin
            state_d       = ST_HOLD_RSP;
            rsp_valid_d   = 1'b1;
            rsp_code_d    = RESP_ERR;
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b0;
          end else begin
            state_d     = ST_SEND_CMD;
            calc_cmd_d  = req_cmd;
            calc_data_d = req_op1;
          end
        end
      end
      ST_SEND_CMD: begin
        state_d     = ST_SEND_OP2;
        calc_data_d = op2_q;
      end
      ST_SEND_OP2: begin
        state_d   = ST_WAIT_RESP;
        timer_clr = 1'b1;
      end
      ST_WAIT_RESP: begin
        if (calc_resp != RESP_NONE) begin
          state_d       = ST_HOLD_RSP;
          rsp_valid_d   = 1'b1;
          rsp_code_d    = calc_resp;
          rsp_data_d    = calc_out_data;
          rsp_timeout_d = 1'b0;
        end else begin
          timer_en = 1'b1;
          if (timer_tc) begin
            state_d       = ST_HOLD_RSP;
            rsp_valid_d   = 1'b1;
            rsp_code_d    = RESP_NONE;
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      ST_HOLD_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed self-checking bench for calc1_port_driver (TIMEOUT_CYCLES = 64).
module tb_calc1_port_driver;

  logic        c_clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  calc_cmd;
  logic [31:0] calc_data;
  logic [1:0]  calc_resp;
  logic [31:0] calc_out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_code;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        err_spurious;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  calc1_port_driver #(.TIMEOUT_CYCLES(64)) dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cmd       (req_cmd),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .calc_cmd      (calc_cmd),
    .calc_data     (calc_data),
    .calc_resp     (calc_resp),
    .calc_out_data (calc_out_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_code      (rsp_code),
    .rsp_data      (rsp_data),
    .rsp_timeout   (rsp_timeout),
    .err_spurious  (err_spurious),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  // advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_op1   = op1;
    req_op2   = op2;
    step();
    req_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0;
    req_cmd = '0;
    req_op1 = '0;
    req_op2 = '0;
    calc_resp = '0;
    calc_out_data = '0;
    rsp_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_calc_cmd", 32'(calc_cmd), 32'd0);
    chk("rst_calc_data", calc_data, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_code", 32'(rsp_code), 32'd0);
    chk("rst_err", 32'(err_spurious), 32'd0);
    reset = 1'b1;
    step();
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_state", 32'(dbg_state), 32'd0);

    // add: op1 = op2 = 1FFF_FFFF, stub answers at k+5
    send_req(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    chk("add_k1_cmd", 32'(calc_cmd), 32'd1);
    chk("add_k1_data", calc_data, 32'h1FFF_FFFF);
    chk("add_k1_req_ready", 32'(req_ready), 32'd0);
    step();
    chk("add_k2_cmd", 32'(calc_cmd), 32'd0);
    chk("add_k2_data", calc_data, 32'h1FFF_FFFF);
    step();
    chk("add_k3_data", calc_data, 32'd0);
    chk("add_k3_state", 32'(dbg_state), 32'd3);
    step();
    chk("add_k4_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    calc_resp = 2'd1;
    calc_out_data = 32'h3FFF_FFFE;
    step();
    calc_resp = 2'd0;
    calc_out_data = 32'd0;
    chk("add_k6_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_k6_rsp_code", 32'(rsp_code), 32'd1);
    chk("add_k6_rsp_data", rsp_data, 32'h3FFF_FFFE);
    chk("add_k6_timeout", 32'(rsp_timeout), 32'd0);
    take_rsp();
    chk("add_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("add_idle_req_ready", 32'(req_ready), 32'd1);

    // timeout: silent stub, result expected at k+67
    send_req(4'd2, 32'h10, 32'h20);
    for (int i = 0; i < 65; i++) step();
    chk("to_k66_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("to_k67_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_k67_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_k67_code", 32'(rsp_code), 32'd0);
    chk("to_k67_data", rsp_data, 32'd0);
    chk("to_err", 32'(err_spurious), 32'd0);

    // backpressure on the held timeout result with a new request pending
    req_valid = 1'b1;
    req_cmd = 4'd5;
    req_op1 = 32'd7;
    req_op2 = 32'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_timeout", 32'(rsp_timeout), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_calc_cmd", 32'(calc_cmd), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_h1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_h1_req_ready", 32'(req_ready), 32'd1);
    chk("bp_h1_calc_cmd", 32'(calc_cmd), 32'd0);
    step();
    req_valid = 1'b0;
    chk("bp_acc_cmd", 32'(calc_cmd), 32'd5);
    chk("bp_acc_data", calc_data, 32'd7);
    step();
    chk("bp_op2_data", calc_data, 32'd3);
    step();
    calc_resp = 2'd2;
    calc_out_data = 32'hDEAD_BEEF;
    step();
    calc_resp = 2'd0;
    calc_out_data = 32'd0;
    chk("bp_rsp_valid_min_lat", 32'(rsp_valid), 32'd1);
    chk("bp_rsp_code", 32'(rsp_code), 32'd2);
    chk("bp_rsp_data", rsp_data, 32'hDEAD_BEEF);
    chk("bp_rsp_timeout", 32'(rsp_timeout), 32'd0);
    take_rsp();

    // filter: cmd 3
    send_req(4'd3, 32'h11, 32'h22);
`ifdef CALC1_DRV_CMD_FILTER_EN
    chk("flt_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("flt_rsp_code", 32'(rsp_code), 32'd2);
    chk("flt_rsp_data", rsp_data, 32'd0);
    chk("flt_timeout", 32'(rsp_timeout), 32'd0);
    chk("flt_calc_cmd", 32'(calc_cmd), 32'd0);
    chk("flt_calc_data", calc_data, 32'd0);
    take_rsp();
`else
    chk("nf_k1_cmd", 32'(calc_cmd), 32'd3);
    chk("nf_k1_data", calc_data, 32'h11);
    chk("nf_k1_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("nf_k2_data", calc_data, 32'h22);
    step();
    calc_resp = 2'd3;
    calc_out_data = 32'h55;
    step();
    calc_resp = 2'd0;
    calc_out_data = 32'd0;
    chk("nf_rsp_code", 32'(rsp_code), 32'd3);
    chk("nf_rsp_data", rsp_data, 32'h55);
    take_rsp();
`endif
    chk("flt_idle_req_ready", 32'(req_ready), 32'd1);

    // spurious response during SEND_OP2
    send_req(4'd6, 32'h100, 32'd4);
    step();
    calc_resp = 2'd1;
    calc_out_data = 32'hBAD;
    step();
    calc_resp = 2'd0;
    calc_out_data = 32'd0;
    chk("sp_err", 32'(err_spurious), 32'd1);
    chk("sp_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("sp_state", 32'(dbg_state), 32'd3);
    step();
    calc_resp = 2'd1;
    calc_out_data = 32'h10;
    step();
    calc_resp = 2'd0;
    calc_out_data = 32'd0;
    chk("sp_rsp_valid2", 32'(rsp_valid), 32'd1);
    chk("sp_rsp_code", 32'(rsp_code), 32'd1);
    chk("sp_rsp_data", rsp_data, 32'h10);
    take_rsp();
    chk("sp_err_sticky", 32'(err_spurious), 32'd1);

    // reset during WAIT_RESP
    send_req(4'd1, 32'd5, 32'd6);
    step();
    step();
    chk("rw_state", 32'(dbg_state), 32'd3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rw_calc_cmd", 32'(calc_cmd), 32'd0);
    chk("rw_calc_data", calc_data, 32'd0);
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_rsp_code", 32'(rsp_code), 32'd0);
    chk("rw_rsp_data", rsp_data, 32'd0);
    chk("rw_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rw_err", 32'(err_spurious), 32'd0);
    chk("rw_req_ready", 32'(req_ready), 32'd0);
    step();
    chk("rw_rel_req_ready", 32'(req_ready), 32'd1);
    step();
    calc_resp = 2'd1;
    calc_out_data = 32'hB;
    step();
    calc_resp = 2'd0;
    calc_out_data = 32'd0;
    chk("rw_late_err", 32'(err_spurious), 32'd1);
    chk("rw_late_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("rw_late_rsp_valid2", 32'(rsp_valid), 32'd0);
    chk("rw_late_state", 32'(dbg_state), 32'd0);
    chk("rw_late_calc_cmd", 32'(calc_cmd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
